// File: rtl/riscv_ifu.sv
// riscv_ifu: fetch unit driving a 1-cycle IMEM into a DEPTH-entry FIFO with redirect flush; stall_cnt port when RISCV_IFU_PERF_EN is defined
module riscv_ifu #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sft_rst,
  output logic                       imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [ILEN-1:0]            imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [ILEN-1:0]            id_instr,
  output logic [XLEN-1:0]            id_pc
`ifdef RISCV_IFU_PERF_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            run;
  logic            pop;
  logic            push;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_nxt;
  logic [AW-1:0]   rd_nxt;
  logic [31:0]     occ;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [ILEN-1:0] instr_q [DEPTH];

  // occ counts buffered plus in-flight entries net of this cycle's pop: the fetch credit
  always_comb begin
    id_valid  = (count != '0) & ~redirect_valid;
    pop       = id_valid & id_ready;
    push      = inflight & ~redirect_valid;
    occ       = 32'(count) + 32'(inflight) - 32'(pop);
    imem_req  = run & ~redirect_valid & (occ < 32'(DEPTH));
    imem_addr = fetch_pc[IMEM_ADDR_WIDTH+1:2];
    wr_nxt    = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
    rd_nxt    = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
    id_instr  = (count != '0) ? instr_q[rd_ptr] : '0;
    id_pc     = (count != '0) ? pc_q[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (sft_rst) begin
      run         <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      run         <= 1'b1;
      inflight    <= imem_req;
      inflight_pc <= imem_req ? fetch_pc : inflight_pc;
      fetch_pc    <= redirect_valid ? (redirect_pc & ~XLEN'(3)) : imem_req ? fetch_pc + XLEN'(4) : fetch_pc;
      count       <= redirect_valid ? '0 : count + CW'(push) - CW'(pop);
      wr_ptr      <= redirect_valid ? '0 : push ? wr_nxt : wr_ptr;
      rd_ptr      <= redirect_valid ? '0 : pop ? rd_nxt : rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= inflight_pc;
      instr_q[wr_ptr] <= imem_rdata;
    end
  end

`ifdef RISCV_IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (sft_rst)
      stall_cnt <= '0;
    else if (run & ~id_valid & ~redirect_valid & ~&stall_cnt)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_riscv_ifu.sv
// tb_riscv_ifu: directed stimulus for riscv_ifu, checked each cycle against a PC-stream model
// plus literal expectations; stall_cnt checks when RISCV_IFU_PERF_EN is defined
module tb_riscv_ifu;
  localparam int DEPTH = 4;
  localparam logic [63:0] RESET_PC = '0;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sft_rst = 1'b0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
`ifdef RISCV_IFU_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] s0;
`endif
  int tests = 0;
  int fails = 0;

  logic [63:0] exp_id, exp_fetch, held_pc, outst;
  logic [31:0] held_instr, exp_stall;
  logic        held, exp_run, exp_infl, exp_req;

  riscv_ifu dut (
    .clk(clk), .rst_n(rst_n), .sft_rst(sft_rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef RISCV_IFU_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // IMEM holds its own word index: IMEM[i] = i
  always @(posedge clk) if (imem_req) imem_rdata <= 32'(imem_addr);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] pc);
    return 32'(pc[11:2]);
  endfunction

  // Model: the stream ID must see is consecutive PCs from the last restart point;
  // (exp_fetch - exp_id)/4 is the number of issued entries not yet handed to ID.
  always @(negedge clk) begin
    if (rst_n) begin
      outst = (exp_fetch - exp_id) >> 2;
      check("id_valid", id_valid, !redirect_valid && (outst - 64'(exp_infl)) != 0);
      if (id_valid) begin
        check("id_pc", id_pc, exp_id);
        check("id_instr", id_instr, word_of(exp_id));
      end
      if (held && !redirect_valid) begin
        check("hold_valid", id_valid, 1);
        check("hold_pc", id_pc, held_pc);
        check("hold_instr", id_instr, held_instr);
      end
      exp_req = exp_run && !redirect_valid && (outst - 64'(id_valid && id_ready)) < DEPTH;
      check("imem_req", imem_req, exp_req);
      if (imem_req) check("imem_addr", imem_addr, exp_fetch[11:2]);
`ifdef RISCV_IFU_PERF_EN
      check("stall_cnt", stall_cnt, exp_stall);
`endif
    end
    if (!rst_n || sft_rst) begin
      exp_id = RESET_PC;
      exp_fetch = RESET_PC;
      held = 0;
      exp_run = 0;
      exp_infl = 0;
      exp_stall = 0;
    end else begin
      if (exp_run && !id_valid && !redirect_valid && exp_stall != 32'hFFFF_FFFF) exp_stall++;
      if (redirect_valid) begin
        exp_id = redirect_pc & ~64'd3;
        exp_fetch = exp_id;
        held = 0;
        exp_infl = 0;
      end else begin
        if (id_valid && id_ready) exp_id += 4;
        if (imem_req) exp_fetch += 4;
        exp_infl = imem_req;
        held = id_valid && !id_ready;
        held_pc = id_pc;
        held_instr = id_instr;
      end
      exp_run = 1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(3);
    check("rst_valid", id_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_pc", id_pc, 0);
    check("rst_instr", id_instr, 0);
`ifdef RISCV_IFU_PERF_EN
    check("rst_stall", stall_cnt, 0);
`endif
    rst_n = 1;
    step; check("t1_req", imem_req, 1); check("t1_addr0", imem_addr, 0); check("t1_nv0", id_valid, 0);
    step; check("t1_addr1", imem_addr, 1); check("t1_nv1", id_valid, 0);
    step; check("t1_v", id_valid, 1); check("t1_pc0", id_pc, 0); check("t1_i0", id_instr, 0);
`ifdef RISCV_IFU_PERF_EN
    check("t1_stall", stall_cnt, 2);
`endif
    step; check("t1_pc4", id_pc, 4); check("t1_i1", id_instr, 1);
    step; check("t1_pc8", id_pc, 8); check("t1_i2", id_instr, 2);
    id_ready = 0;
    step(10);
    check("t2_valid", id_valid, 1);
    check("t2_pc", id_pc, 8);
    check("t2_req", imem_req, 0);
    check("t2_fetch", imem_addr, 6);
    id_ready = 1;
    for (int k = 1; k <= 6; k++) begin
      step;
      check("t2_flow_v", id_valid, 1);
      check("t2_flow_pc", id_pc, 64'(8 + 4 * k));
    end
    sft_rst = 1; redirect_valid = 1; redirect_pc = 64'h800;
    step;
    sft_rst = 0; redirect_valid = 0; #1;
    check("t4_nv", id_valid, 0); check("t4_noreq", imem_req, 0);
    step; check("t4_req", imem_req, 1); check("t4_addr", imem_addr, 0);
    step; check("t4_nv2", id_valid, 0);
    step; check("t4_v", id_valid, 1); check("t4_pc", id_pc, 0);
    step(2);
    check("t3_pc8", id_pc, 8);
    id_ready = 0;
    step(2);
    check("t3_full", imem_req, 0);
    check("t3_head", id_pc, 8);
`ifdef RISCV_IFU_PERF_EN
    s0 = stall_cnt;
`endif
    redirect_valid = 1; redirect_pc = 64'h103; id_ready = 1; #1;
    check("t3_rv_nv", id_valid, 0);
    step;
    redirect_valid = 0; #1;
    check("t3_nv1", id_valid, 0); check("t3_req", imem_req, 1); check("t3_addr", imem_addr, 10'h40);
    step; check("t3_nv2", id_valid, 0);
    step; check("t3_v", id_valid, 1); check("t3_pc100", id_pc, 64'h100); check("t3_i40", id_instr, 32'h40);
`ifdef RISCV_IFU_PERF_EN
    check("t6_stall", stall_cnt, s0 + 32'd2);
`endif
    step; check("t3_pc104", id_pc, 64'h104); check("t3_i41", id_instr, 32'h41);
    redirect_valid = 1; redirect_pc = '1;
    step;
    redirect_valid = 0; #1;
    check("t5_addr", imem_addr, 10'h3FF); check("t5_req", imem_req, 1);
    step(2);
    check("t5_v", id_valid, 1); check("t5_pc_top", id_pc, 64'hFFFF_FFFF_FFFF_FFFC); check("t5_i_top", id_instr, 32'h3FF);
    step; check("t5_pc_wrap", id_pc, 0); check("t5_i_wrap", id_instr, 0);
    redirect_valid = 1; redirect_pc = 64'h200;
    step;
    redirect_pc = 64'h301;
    step;
    redirect_valid = 0;
    step(2);
    check("t7_v", id_valid, 1); check("t7_pc", id_pc, 64'h300);
    step; check("t7_pc2", id_pc, 64'h304);
    step(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
